// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a FIFO read port: start bit, data LSB first,
// optional parity bit, one stop bit. Back-to-back frames chain without an idle gap.
module fifo_uart_tx #(
    parameter int unsigned bits         = 8,
    parameter int unsigned clks_per_bit = 16,
    parameter int unsigned parity_en    = 0,
    parameter int unsigned parity_odd   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pndng,
    input  logic [bits-1:0] din,
    output logic            pop,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);

    localparam int unsigned BaudW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int unsigned BitW  = (bits > 1) ? $clog2(bits) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(clks_per_bit - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(bits - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [bits-1:0]   shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_tick;
    logic              can_load;

    assign last_tick = (baud_q == BaudLast);
    assign can_load  = (state_q == StIdle) || ((state_q == StStop) && last_tick);
    assign pop       = ~rst & can_load & pndng & en;

    always_comb begin
        state_d  = state_q;
        baud_d   = (state_q == StIdle || last_tick) ? '0 : baud_q + BaudW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (last_tick) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (last_tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BitW'(1);
                    if (bit_q == BitLast) state_d = (parity_en != 0) ? StParity : StStop;
                end
            end
            StParity: begin
                if (last_tick) state_d = StStop;
            end
            StStop: begin
                if (last_tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Loading overrides the stop/idle transition so frames chain back to back.
        if (pop) begin
            state_d  = StStart;
            shift_d  = din;
            parity_d = (^din) ^ (parity_odd != 0);
            baud_d   = '0;
        end

        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StStop) && (baud_d == BaudLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: four configurations fed by FIFO models, a negedge
// monitor checks every frame cycle against hand-computed bit sequences.
module tb_fifo_uart_tx;

    typedef struct packed {
        logic [15:0] b;
        int          n;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       pndng_v [4];
    logic [7:0] din_v   [4];
    logic       pop_v   [4];
    logic       tx_v    [4];
    logic       busy_v  [4];
    logic       fd_v    [4];

    logic [7:0] fq [4][$];
    frame_t     eq [4][$];
    frame_t     cur [4];
    bit         active [4];
    int         cnt [4];
    int         pops [4];
    int         last_pop [4];
    int         prev_pop [4];
    int         cyc;
    int         n_checks;
    int         n_fail;
    int         p0;

    fifo_uart_tx #(.bits(8), .clks_per_bit(4), .parity_en(0), .parity_odd(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .pndng(pndng_v[0]), .din(din_v[0]),
        .pop(pop_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
    fifo_uart_tx #(.bits(8), .clks_per_bit(4), .parity_en(1), .parity_odd(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .pndng(pndng_v[1]), .din(din_v[1]),
        .pop(pop_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
    fifo_uart_tx #(.bits(8), .clks_per_bit(4), .parity_en(1), .parity_odd(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .pndng(pndng_v[2]), .din(din_v[2]),
        .pop(pop_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));
    fifo_uart_tx #(.bits(4), .clks_per_bit(2), .parity_en(0), .parity_odd(0)) u3 (
        .clk(clk), .rst(rst), .en(en), .pndng(pndng_v[3]), .din(din_v[3][3:0]),
        .pop(pop_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cpb(int k);
        return (k == 3) ? 2 : 4;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void refresh();
        for (int k = 0; k < 4; k++) begin
            pndng_v[k] = (fq[k].size() != 0);
            din_v[k]   = (fq[k].size() != 0) ? fq[k][0] : 8'hEE;
        end
    endfunction

    // FIFO read side: the head advances on the edge where pop was high.
    always @(posedge clk) begin
        logic p [4];
        for (int k = 0; k < 4; k++) p[k] = pop_v[k];
        #1;
        for (int k = 0; k < 4; k++)
            if (p[k] && fq[k].size() != 0) void'(fq[k].pop_front());
        refresh();
    end

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                active[k] = 1'b0;
                chk("rst_tx", 32'(tx_v[k]), 32'd1);
                chk("rst_busy", 32'(busy_v[k]), 32'd0);
                chk("rst_pop", 32'(pop_v[k]), 32'd0);
                chk("rst_frame_done", 32'(fd_v[k]), 32'd0);
            end else begin
                if (active[k]) begin
                    cnt[k]++;
                    chk("tx_bit", 32'(tx_v[k]), 32'(cur[k].b[(cnt[k] - 1) / cpb(k)]));
                    chk("busy_frame", 32'(busy_v[k]), 32'd1);
                    chk("frame_done", 32'(fd_v[k]), 32'(cnt[k] == cur[k].n * cpb(k)));
                    if (cnt[k] == cur[k].n * cpb(k)) active[k] = 1'b0;
                end else begin
                    chk("idle_tx", 32'(tx_v[k]), 32'd1);
                    chk("idle_busy", 32'(busy_v[k]), 32'd0);
                    chk("idle_frame_done", 32'(fd_v[k]), 32'd0);
                end
                if (pop_v[k] === 1'b1) begin
                    pops[k]++;
                    prev_pop[k] = last_pop[k];
                    last_pop[k] = cyc;
                    chk("pop_inside_frame", 32'(active[k]), 32'd0);
                    chk("pop_expected", 32'(eq[k].size() != 0), 32'd1);
                    if (eq[k].size() != 0) cur[k] = eq[k].pop_front();
                    active[k] = 1'b1;
                    cnt[k]    = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(int k, logic [7:0] w, logic [15:0] b, int n);
        frame_t f;
        f.b = b;
        f.n = n;
        fq[k].push_back(w);
        eq[k].push_back(f);
        refresh();
    endtask

    task automatic wait_pop(int k, int budget);
        int s = pops[k];
        int i = 0;
        while (pops[k] == s && i < budget) begin
            tick();
            i++;
        end
        chk("pop_wait", 32'(pops[k] != s), 32'd1);
    endtask

    task automatic drain(int k, int budget);
        int i = 0;
        while (!(eq[k].size() == 0 && !active[k] && fq[k].size() == 0) && i < budget) begin
            tick();
            i++;
        end
        chk("drain_done", 32'(i < budget), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        en       = 1'b1;
        rst      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            active[k]   = 1'b0;
            cnt[k]      = 0;
            pops[k]     = 0;
            last_pop[k] = 0;
            prev_pop[k] = 0;
        end
        refresh();
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
        p0 = pops[0];
        push(0, 8'hA5, 16'(10'b1101001010), 10);
        drain(0, 200);
        chk("a5_pop_count", 32'(pops[0] - p0), 32'd1);

        // 0x00 then 0xFF back to back
        p0 = pops[0];
        push(0, 8'h00, 16'(10'b1000000000), 10);
        push(0, 8'hFF, 16'(10'b1111111110), 10);
        wait_pop(0, 10);
        wait_pop(0, 60);
        chk("b2b_pop_gap", 32'(last_pop[0] - prev_pop[0]), 32'd40);
        chk("b2b_fifo_empty", 32'(pndng_v[0]), 32'd0);
        drain(0, 200);
        chk("b2b_pop_count", 32'(pops[0] - p0), 32'd2);

        // 0x07 with even parity (bit 1) and odd parity (bit 0), 44-cycle frames
        push(1, 8'h07, 16'(11'b11000001110), 11);
        drain(1, 200);
        push(2, 8'h07, 16'(11'b10000001110), 11);
        drain(2, 200);

        // reset during DATA bit 3 of 0x3C, then 0x5A must start with a fresh pop
        push(0, 8'h3C, 16'(10'b1001111000), 10);
        wait_pop(0, 10);
        repeat (17) tick();
        chk("pre_rst_busy", 32'(busy_v[0]), 32'd1);
        push(0, 8'h5A, 16'(10'b1010110100), 10);
        p0 = pops[0];
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx_v[0]), 32'd1);
        chk("async_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("async_rst_pop", 32'(pop_v[0]), 32'd0);
        tick();
        rst = 1'b0;
        wait_pop(0, 5);
        drain(0, 200);
        chk("post_rst_pop_count", 32'(pops[0] - p0), 32'd1);

        // en=0 with data pending: no pop, line stays idle
        en = 1'b0;
        p0 = pops[0];
        push(0, 8'h3C, 16'(10'b1001111000), 10);
        repeat (100) tick();
        chk("en0_no_pop", 32'(pops[0] - p0), 32'd0);
        en = 1'b1;
        drain(0, 200);

        // en dropped at cycle 10 of a frame: frame completes, next word held back
        push(0, 8'h12, 16'(10'b1000100100), 10);
        push(0, 8'h34, 16'(10'b1001101000), 10);
        wait_pop(0, 10);
        repeat (9) tick();
        en = 1'b0;
        p0 = pops[0];
        repeat (60) tick();
        chk("en_drop_no_pop", 32'(pops[0] - p0), 32'd0);
        chk("en_drop_idle", 32'(busy_v[0]), 32'd0);
        chk("en_drop_pending", 32'(pndng_v[0]), 32'd1);
        en = 1'b1;
        drain(0, 200);

        // 4-bit, 2 clocks per bit: 0x9 -> 0,1,0,0,1,1 and 0x6 -> 0,0,1,1,0,1
        push(3, 8'h09, 16'(6'b110010), 6);
        push(3, 8'h06, 16'(6'b101100), 6);
        drain(3, 100);
        chk("u3_pop_gap", 32'(last_pop[3] - prev_pop[3]), 32'd12);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
